// File: rtl/timer_pkg.sv
// Shared timer definitions: data width, default queue depth and the timer word type.
package timer_pkg;

    localparam int TIMER_DATA_W  = 16;
    localparam int TIMER_Q_DEPTH = 8;

    typedef logic [15:0] timer_word_t;

endpackage

// File: rtl/timer_queue_ram.sv
// Register-array storage for timer_queue: one synchronous write port, one asynchronous read port.
module timer_queue_ram
    import timer_pkg::*;
#(
    parameter int DEPTH  = TIMER_Q_DEPTH,
    parameter int DATA_W = TIMER_DATA_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; occupancy tracking masks stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/timer_queue.sv
// In-order FIFO between the timer stage and its consumer, with first-word-fall-through head.
// Optional drop counter/flag outputs are built when TIMER_QUEUE_DROP_CNT_EN is defined.
module timer_queue
    import timer_pkg::*;
#(
    parameter int DEPTH  = TIMER_Q_DEPTH,
    parameter int DATA_W = TIMER_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       t_valid,
    input  logic [DATA_W-1:0]          t_out,
    output logic                       t_en,
    input  logic                       deq,
    output logic [DATA_W-1:0]          q_out,
    output logic [$clog2(DEPTH+1)-1:0] q_len,
    output logic                       q_empty,
    output logic                       q_full
`ifdef TIMER_QUEUE_DROP_CNT_EN
   ,output logic [15:0]                drop_cnt,
    output logic                       drop_flag
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;

    assign q_empty = (q_len == '0);
    assign q_full  = (q_len == LW'(DEPTH));
    assign t_en    = !q_full;

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign pop_ok  = deq && !q_empty;
    assign push_ok = t_valid && (!q_full || pop_ok);
    assign drop    = t_valid && q_full && !pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_len  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   q_len <= q_len + LW'(1);
                2'b01:   q_len <= q_len - LW'(1);
                default: q_len <= q_len;
            endcase
        end
    end

    timer_queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (t_out),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign q_out = q_empty ? '0 : rd_data;

`ifdef TIMER_QUEUE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt  <= '0;
            drop_flag <= 1'b0;
        end else begin
            drop_flag <= drop;
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: doc/timer_queue.md
# timer_queue

Buffers the 16-bit values produced by the upstream timer stage into a small in-order FIFO and hands them to a consumer through a pop strobe. It drives the timer's `t_en` enable as a request signal, de-asserting it when the buffer is full. It consumes the timer's `t_valid`/`t_out` pair directly and runs in the same single clock domain.

## Interface

- `DEPTH`, default 8: number of 16-bit entries; power of two, from 2 to 16.
- `DATA_W`, default 16: entry width; must match the timer output width.

Ports:

- `clk`  in  1: system clock, shared with the timer.
- `rst`  in  1: **reset is synchronous and active-high**; one clock, no other clock domains.
- `t_valid`  in  1: the timer output in `t_out` is valid this cycle (push request).
- `t_out`  in  DATA_W: value from the timer.
- `t_en`  out  1: enable to the timer; high while the queue can accept data.
- `deq`  in  1: consumer pop strobe; one entry is removed per cycle that `deq` is high and the queue is not empty.
- `q_out`  out  DATA_W: head entry; 0 when empty.
- `q_len`  out  $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- `q_empty`  out  1: `q_len == 0`.
- `q_full`  out  1: `q_len == DEPTH`.

## Operation

- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits wide, plus an explicit occupancy counter. Pointers wrap from DEPTH-1 to 0.
- Push is accepted when `t_valid && (!q_full || pop_ok)`, where `pop_ok = deq && !q_empty`.
- On an accepted push, `mem[wr_ptr] <= t_out` and `wr_ptr` increments.
- On `pop_ok`, `rd_ptr` increments.
- Occupancy update:
  - `q_len` increments on push only.
  - `q_len` decrements on pop only.
  - `q_len` is unchanged when push and pop happen together.
- Simultaneous push and pop:
  - When full, both happen and `q_len` stays at DEPTH.
  - When empty, only the push happens; the pop is ignored and the new value appears at the head on the next cycle.
- Dropped data: `t_valid` while full and not popping loses the value silently. Queue contents and pointers are unchanged.
- `deq` while empty has no effect and no error.
- `t_en = !q_full`, combinational from the registered occupancy.
- `q_out = q_empty ? 0 : mem[rd_ptr]`, which gives first-word-fall-through behaviour.
- Values are stored verbatim. The timer has already truncated them to its 16 least-significant bits; this block applies no arithmetic to the data.

## Timing

- Reset values:
  - `wr_ptr = rd_ptr = 0`, `q_len = 0`.
  - `q_empty = 1`, `q_full = 0`, `t_en = 1`, `q_out = 0`.
  - `mem` contents are not reset.
- Reset mid-operation: the queue empties on the first clock edge with `rst` high, and all buffered data is discarded. `rst` has priority over push and pop in the same cycle.
- Push latency: a value sampled at edge N is visible on `q_out` after edge N when the queue was empty; `q_len`/`q_empty` update at the same edge.
- Pop latency: the next entry appears on `q_out` immediately after the edge that sampled `deq`.
- Throughput: one push and one pop per cycle.
- `t_en` falls in the cycle after the push that fills the queue. A `t_valid` already in flight from the timer during that cycle is dropped, unless a pop occurs in the same cycle.

## Configuration

- Macro: `TIMER_QUEUE_DROP_CNT_EN`.
- Defined:
  - Adds output `drop_cnt` (16 bits), reset to 0.
  - It increments by 1 for every dropped push and saturates at 0xFFFF.
  - Adds output `drop_flag`, high for one cycle after each drop.
- Not defined:
  - Both ports are absent.
  - Drops are silent and no counter logic is synthesised.

## Structure

- Shared package `timer_pkg` holds:
  - `TIMER_DATA_W = 16`, shared with the timer as the `DATA_W` default.
  - `TIMER_Q_DEPTH = 8`.
  - typedef `timer_word_t` (logic [15:0]).
- Sub-module: `timer_queue_ram`, a DEPTH×DATA_W register array with one write port and one asynchronous read port.
  - The pointer and occupancy control logic stays in `timer_queue`.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `t_valid = 1` → `q_len = 0`, `q_empty = 1`, `t_en = 1`, `q_out = 0`.
- **Fill:** push 0x0001..0x0008 on consecutive cycles with `deq = 0`.
  - Expect `q_full = 1`, `t_en = 0`, `q_len = 8`.
  - A ninth push of 0x0009 is dropped, and `drop_cnt = 1` when the macro is defined.
  - Then pop 8 times → 0x0001..0x0008 in order, then `q_empty = 1`, `q_out = 0`.
- **Full with push and pop together:** when full, push 0xBEEF and pop in the same cycle.
  - Expect `q_len` stays 8, `q_out` advances.
  - 0xBEEF is returned last.
- **Empty with push and pop together:** when empty, push 0x1234 with `deq = 1` → `q_len = 1`, `q_out = 0x1234` next cycle.
- **Wrap-around:** run 20 interleaved push/pop cycles so the pointers wrap twice → output sequence equals input sequence, including 0xFFFF and 0x0000.
- **Mid-operation reset:** with `q_len = 5`, pulse `rst` for 1 cycle while `t_valid` and `deq` are high → `q_len = 0`, and the next push of 0x00AA is at the head.
